// File: rtl/bmp_write.sv
// Frame capture to SD card as an uncompressed 24-bit BMP file.
// Header, pixel stream and zero padding are produced one byte per controller request.
module bmp_write #(
    parameter logic [15:0] IMG_W    = 16'd640,
    parameter logic [15:0] IMG_H    = 16'd480,
    parameter logic [31:0] BASE_SEC = 32'd32000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sd_init_done,
    input  logic        capture,
    output logic        ready,
    output logic [3:0]  state_code,
    output logic        read_req,
    input  logic        read_req_ack,
    output logic        bmp_data_rd_en,
    input  logic [23:0] bmp_data,
    output logic        sd_sec_write,
    output logic [31:0] sd_sec_write_addr,
    output logic [7:0]  sd_sec_write_data,
    input  logic        sd_sec_write_data_req,
    input  logic        sd_sec_write_end,
    output logic [31:0] file_sec_base
);

    localparam logic [31:0] IMG_BYTES = {16'd0, IMG_W} * {16'd0, IMG_H} * 32'd3;
    localparam logic [31:0] FILE_LEN  = IMG_BYTES + 32'd54;
    localparam logic [31:0] NSEC      = (FILE_LEN + 32'd511) >> 9;
    localparam logic [31:0] SLOT      = ((NSEC + 32'd7) >> 3) << 3;

    // Byte 0 sits in the low bits, so the header reads out little-endian.
    localparam logic [431:0] HDR = {
        32'd0, 32'd0, 32'd2835, 32'd2835, IMG_BYTES, 32'd0,
        16'd24, 16'd1, {16'd0, IMG_H}, {16'd0, IMG_W},
        32'd40, 32'd54, 32'd0, FILE_LEN, 8'h4D, 8'h42
    };

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WRITE, S_END} state_t;

    state_t      state, state_d;
    logic [3:0]  code_q, code_d;
    logic [31:0] byte_cnt, byte_cnt_d;
    logic [31:0] sec_cnt, sec_cnt_d;
    logic [31:0] slot_addr, slot_addr_d;
    logic [31:0] addr_d, base_d;
    logic [23:0] pixel, pixel_d, cur_pix;
    logic [1:0]  phase, phase_d;
    logic        pix_load;
    logic        read_req_d, sec_wr_d;
    logic [7:0]  data_d, src_byte;
    logic [8:0]  hidx;
    logic        consume, in_pix;

    assign consume = sd_sec_write_data_req && (state == S_WRITE) && sd_init_done;
    assign in_pix  = (byte_cnt >= 32'd54) && (byte_cnt < FILE_LEN);

    // Next pixel is fetched after the last header byte and after every R byte.
    assign bmp_data_rd_en = consume &&
        ((byte_cnt == 32'd53) ||
         (in_pix && (phase == 2'd2) && (byte_cnt != FILE_LEN - 32'd1)));

    assign state_code = sd_init_done ? code_q : 4'd0;
    assign ready      = sd_init_done && (code_q == 4'd1);

    always_comb begin
        hidx     = {byte_cnt[5:0], 3'b000};
        cur_pix  = pix_load ? bmp_data : pixel;
        src_byte = 8'h00;
        if (byte_cnt < 32'd54) begin
            src_byte = HDR[hidx +: 8];
        end else if (byte_cnt < FILE_LEN) begin
            case (phase)
                2'd0:    src_byte = cur_pix[7:0];
                2'd1:    src_byte = cur_pix[15:8];
                default: src_byte = cur_pix[23:16];
            endcase
        end
    end

    always_comb begin
        state_d     = state;
        byte_cnt_d  = byte_cnt;
        sec_cnt_d   = sec_cnt;
        slot_addr_d = slot_addr;
        addr_d      = sd_sec_write_addr;
        base_d      = file_sec_base;
        phase_d     = phase;
        pixel_d     = cur_pix;
        read_req_d  = read_req;
        sec_wr_d    = sd_sec_write;
        data_d      = sd_sec_write_data;
        unique case (state)
            S_IDLE: begin
                if (capture) begin
                    addr_d     = slot_addr;
                    byte_cnt_d = 32'd0;
                    sec_cnt_d  = 32'd0;
                    read_req_d = 1'b1;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (read_req_ack) begin
                    read_req_d = 1'b0;
                    data_d     = HDR[7:0];
                    sec_wr_d   = 1'b1;
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                data_d   = src_byte;
                sec_wr_d = 1'b1;
                if (consume) begin
                    byte_cnt_d = byte_cnt + 32'd1;
                    if (byte_cnt == 32'd53)
                        phase_d = 2'd0;
                    else if (in_pix)
                        phase_d = (phase == 2'd2) ? 2'd0 : phase + 2'd1;
                end
                if (sd_sec_write_end) begin
                    sec_wr_d  = 1'b0;
                    sec_cnt_d = sec_cnt + 32'd1;
                    if (sec_cnt + 32'd1 < NSEC)
                        addr_d = sd_sec_write_addr + 32'd1;
                    else
                        state_d = S_END;
                end
            end
            S_END: begin
                base_d      = slot_addr;
                slot_addr_d = slot_addr + SLOT;
                sec_wr_d    = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
        if (!sd_init_done) begin
            state_d    = S_IDLE;
            sec_wr_d   = 1'b0;
            read_req_d = 1'b0;
        end
    end

    always_comb begin
        code_d = 4'd0;
        if (sd_init_done) begin
            unique case (state_d)
                S_IDLE:  code_d = 4'd1;
                S_REQ:   code_d = 4'd2;
                S_WRITE: code_d = 4'd3;
                S_END:   code_d = 4'd3;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            code_q            <= 4'd0;
            read_req          <= 1'b0;
            sd_sec_write      <= 1'b0;
            sd_sec_write_addr <= BASE_SEC;
            slot_addr         <= BASE_SEC;
            file_sec_base     <= BASE_SEC;
            sd_sec_write_data <= 8'h00;
            byte_cnt          <= 32'd0;
            sec_cnt           <= 32'd0;
            phase             <= 2'd0;
            pixel             <= 24'd0;
            pix_load          <= 1'b0;
        end else begin
            state             <= state_d;
            code_q            <= code_d;
            read_req          <= read_req_d;
            sd_sec_write      <= sec_wr_d;
            sd_sec_write_addr <= addr_d;
            slot_addr         <= slot_addr_d;
            file_sec_base     <= base_d;
            sd_sec_write_data <= data_d;
            byte_cnt          <= byte_cnt_d;
            sec_cnt           <= sec_cnt_d;
            phase             <= phase_d;
            pixel             <= pixel_d;
            pix_load          <= bmp_data_rd_en;
        end
    end

endmodule

// File: tb/tb_bmp_write.sv
// Randomized bench for bmp_write: SD controller and frame source models,
// with a byte-level file model checked on every consumed byte.
module tb_bmp_write;

    localparam int W    = 8;
    localparam int H    = 32;
    localparam int BASE = 8;
    localparam int NPIX = W * H;
    localparam int FLEN = NPIX * 3 + 54;
    localparam int NSEC = (FLEN + 511) / 512;
    localparam int SLOT = ((NSEC + 7) / 8) * 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        sd_init_done;
    logic        capture;
    logic        ready;
    logic [3:0]  state_code;
    logic        read_req;
    logic        read_req_ack;
    logic        bmp_data_rd_en;
    logic [23:0] bmp_data;
    logic        sd_sec_write;
    logic [31:0] sd_sec_write_addr;
    logic [7:0]  sd_sec_write_data;
    logic        sd_sec_write_data_req;
    logic        sd_sec_write_end;
    logic [31:0] file_sec_base;

    bmp_write #(
        .IMG_W(16'(W)),
        .IMG_H(16'(H)),
        .BASE_SEC(32'(BASE))
    ) dut (
        .clk(clk),
        .rst(rst),
        .sd_init_done(sd_init_done),
        .capture(capture),
        .ready(ready),
        .state_code(state_code),
        .read_req(read_req),
        .read_req_ack(read_req_ack),
        .bmp_data_rd_en(bmp_data_rd_en),
        .bmp_data(bmp_data),
        .sd_sec_write(sd_sec_write),
        .sd_sec_write_addr(sd_sec_write_addr),
        .sd_sec_write_data(sd_sec_write_data),
        .sd_sec_write_data_req(sd_sec_write_data_req),
        .sd_sec_write_end(sd_sec_write_end),
        .file_sec_base(file_sec_base)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [23:0] pix [NPIX];
    logic [7:0]  hdr [54];
    int bidx, pops, secs, pidx, cur_base, slot_idx;
    bit hold, live, pend;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic put(input int off, input int n, input int unsigned v);
        for (int i = 0; i < n; i++) hdr[off + i] = 8'(v >> (8 * i));
    endtask

    function automatic logic [7:0] exp_byte(input int k);
        logic [23:0] p;
        if (k < 54) return hdr[k];
        if (k < FLEN) begin
            p = pix[(k - 54) / 3];
            return 8'(p >> (8 * ((k - 54) % 3)));
        end
        return 8'h00;
    endfunction

    function automatic bit rd_rule(input int k);
        if (k == 53) return 1'b1;
        return (k >= 54) && (k < FLEN - 1) && ((k - 54) % 3 == 2);
    endfunction

    // SD sector-write controller model
    initial begin
        int cnt, gap;
        bit in_sec;
        in_sec = 0; cnt = 0; gap = 0;
        sd_sec_write_data_req = 0;
        sd_sec_write_end = 0;
        forever begin
            @(negedge clk);
            sd_sec_write_data_req = 0;
            sd_sec_write_end = 0;
            live = 0;
            if (!sd_sec_write || hold || rst) begin
                in_sec = 0;
            end else if (!in_sec) begin
                in_sec = 1;
                cnt = 0;
                gap = $urandom_range(1, 3);
            end else if (cnt < 512) begin
                if (gap > 1) gap--;
                else begin
                    sd_sec_write_data_req = 1;
                    live = 1;
                    cnt++;
                    gap = $urandom_range(3, 5);
                    if (cnt == 512) begin
                        if ($urandom_range(0, 1) == 1) begin
                            sd_sec_write_end = 1;
                            cnt = 513;
                        end else begin
                            gap = $urandom_range(1, 3);
                        end
                    end
                end
            end else if (cnt == 512) begin
                if (gap > 1) gap--;
                else begin
                    sd_sec_write_end = 1;
                    cnt = 513;
                end
            end
        end
    end

    // Frame source: pixel valid the cycle after each pop
    initial begin
        pend = 0;
        bmp_data = 24'd0;
        forever begin
            @(negedge clk);
            if (pend) bmp_data = (pidx < NPIX) ? pix[pidx] : 24'd0;
            else bmp_data = 24'($urandom);
            pend = 0;
            #2;
            if (bmp_data_rd_en) begin
                pend = 1;
                pidx = pops;
                pops++;
            end
        end
    end

    // Per-cycle compare against the file model
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                chk("rd_en", bmp_data_rd_en, live && rd_rule(bidx));
                if (!sd_init_done) chk("state_code_noinit", state_code, 0);
                else if (sd_sec_write) chk("state_code_wr", state_code, 3);
                if (live) begin
                    if (bidx % 512 == 0)
                        chk("sec_addr", sd_sec_write_addr, cur_base + bidx / 512);
                    chk("byte", sd_sec_write_data, exp_byte(bidx));
                    case (bidx)
                        0:   chk("pin_B", sd_sec_write_data, 8'h42);
                        1:   chk("pin_M", sd_sec_write_data, 8'h4D);
                        2:   chk("pin_len0", sd_sec_write_data, 8'h36);
                        3:   chk("pin_len1", sd_sec_write_data, 8'h03);
                        10:  chk("pin_off", sd_sec_write_data, 8'h36);
                        22:  chk("pin_h", sd_sec_write_data, 8'h20);
                        28:  chk("pin_bpp", sd_sec_write_data, 8'h18);
                        35:  chk("pin_isz1", sd_sec_write_data, 8'h03);
                        900: chk("pin_pad", sd_sec_write_data, 8'h00);
                        default: ;
                    endcase
                    if (bidx % 512 == 511) secs++;
                    bidx++;
                end
            end
        end
    end

    task automatic wait_ready(input int budget, input string nm);
        int n = 0;
        while (!ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, ready, 1);
    endtask

    task automatic start_file(input int ack_dly, input bit extra);
        int n;
        for (int i = 0; i < NPIX; i++) pix[i] = 24'($urandom);
        wait_ready(50, "ready_before_capture");
        bidx = 0; pops = 0; secs = 0;
        cur_base = BASE + slot_idx * SLOT;
        @(negedge clk) capture = 1;
        @(negedge clk) capture = 0;
        n = 0;
        while (!read_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("read_req_rise", read_req, 1);
        for (int i = 0; i < ack_dly; i++) begin
            @(negedge clk);
            capture = extra && (i == 1);
        end
        capture = 0;
        read_req_ack = 1;
        @(negedge clk) read_req_ack = 0;
        chk("read_req_fall", read_req, 0);
    endtask

    task automatic finish_file(input bit extra);
        int n = 0;
        while (!ready && n < 9000) begin
            @(negedge clk);
            capture = extra && (n == 60);
            n++;
        end
        capture = 0;
        chk("file_done", ready, 1);
        chk("pops", pops, NPIX);
        chk("bytes", bidx, NSEC * 512);
        chk("sectors", secs, NSEC);
        chk("file_sec_base", file_sec_base, cur_base);
        slot_idx++;
        repeat (3) begin
            @(negedge clk);
            chk("no_requeue", read_req, 0);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_code"}, state_code, 0);
        chk({nm, "_ready"}, ready, 0);
        chk({nm, "_req"}, read_req, 0);
        chk({nm, "_rd"}, bmp_data_rd_en, 0);
        chk({nm, "_wr"}, sd_sec_write, 0);
        chk({nm, "_addr"}, sd_sec_write_addr, BASE);
        chk({nm, "_base"}, file_sec_base, BASE);
        chk({nm, "_data"}, sd_sec_write_data, 0);
    endtask

    initial begin
        int n;
        put(0, 1, 'h42); put(1, 1, 'h4D); put(2, 4, FLEN); put(6, 4, 0);
        put(10, 4, 54); put(14, 4, 40); put(18, 4, W); put(22, 4, H);
        put(26, 2, 1); put(28, 2, 24); put(30, 4, 0); put(34, 4, NPIX * 3);
        put(38, 4, 2835); put(42, 4, 2835); put(46, 4, 0); put(50, 4, 0);
        rst = 1; sd_init_done = 0; capture = 0; read_req_ack = 0;
        hold = 0; live = 0; bidx = 0; pops = 0; secs = 0; pidx = 0;
        slot_idx = 0; cur_base = BASE;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 0;
        repeat (3) @(negedge clk);
        chk("code_sd_init", state_code, 0);
        sd_init_done = 1;
        @(negedge clk);
        chk("code_idle", state_code, 1);
        chk("ready_idle", ready, 1);

        start_file(5, 0);
        finish_file(0);
        start_file(5, 1);
        finish_file(1);
        start_file($urandom_range(1, 8), 0);
        finish_file(0);

        // sd_init_done dropped mid-file
        start_file(3, 0);
        n = 0;
        while (bidx < 600 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_sector2", bidx >= 600, 1);
        hold = 1;
        @(negedge clk) sd_init_done = 0;
        #1;
        chk("drop_code", state_code, 0);
        chk("drop_ready", ready, 0);
        @(negedge clk);
        chk("drop_wr", sd_sec_write, 0);
        chk("drop_req", read_req, 0);
        repeat (3) @(negedge clk);
        sd_init_done = 1;
        @(negedge clk);
        chk("ready_back", ready, 1);
        hold = 0;
        start_file(4, 0);
        finish_file(0);

        // async reset mid-file
        start_file(2, 0);
        n = 0;
        while (bidx < 300 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        hold = 1;
        @(negedge clk);
        #1 rst = 1;
        #1 chk_reset_outputs("async_rst");
        repeat (3) begin
            @(negedge clk);
            chk("rst_rd", bmp_data_rd_en, 0);
        end
        rst = 0;
        hold = 0;
        slot_idx = 0;
        start_file(5, 0);
        finish_file(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bmp_write.md
Name: bmp_write

Overview:
- Captures one frame of 24-bit pixels from the frame-buffer read side and stores it on the SD card as an uncompressed BMP file.
- Builds the 54-byte BMP header, streams the pixel bytes, and zero-pads the last 512-byte sector.
- Sits between the SD sector-write controller and the frame read FIFO; it is the write-direction counterpart of the BMP loader.
- Files start on 8-sector-aligned addresses so the loader's 8-sector search finds them.

Parameters:
- IMG_W, 16'd640: image width in pixels. IMG_W*3 must be a multiple of 4, so rows carry no padding.
- IMG_H, 16'd480: image height; written as a positive value (bottom-up rows).
- BASE_SEC, 32'd32000: first sector of the first file slot; must be 8-aligned.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sd_init_done  in  1  SD card initialisation complete
- capture  in  1  start a capture; sampled in S_IDLE only
- ready  out  1  high while in S_IDLE
- state_code  out  4  0: SD initialising, 1: idle, 2: waiting for frame source, 3: writing
- read_req  out  1  request to the frame source to start a frame readout
- read_req_ack  in  1  frame source acknowledges read_req
- bmp_data_rd_en  out  1  single-cycle pop of one pixel
- bmp_data  in  24  pixel, valid the cycle after bmp_data_rd_en; [7:0]=B, [15:8]=G, [23:16]=R
- sd_sec_write  out  1  sector write request, held high until sd_sec_write_end
- sd_sec_write_addr  out  32  sector address
- sd_sec_write_data  out  8  byte to be written
- sd_sec_write_data_req  in  1  controller consumes sd_sec_write_data in this cycle
- sd_sec_write_end  in  1  single-cycle pulse, sector write finished
- file_sec_base  out  32  start sector of the last completed file

Behaviour:
- Derived constants:
  - IMG_BYTES = IMG_W*IMG_H*3.
  - FILE_LEN = IMG_BYTES+54.
  - NSEC = ceil(FILE_LEN/512).
  - SLOT = ceil(NSEC/8)*8.
  - All arithmetic is 32-bit.
- Reset values:
  - state S_IDLE; state_code 0.
  - read_req, bmp_data_rd_en, sd_sec_write all 0.
  - sd_sec_write_addr = BASE_SEC; slot_addr = BASE_SEC; file_sec_base = BASE_SEC.
  - sd_sec_write_data 0; all counters 0.
- sd_init_done low in any state: go to S_IDLE and drop sd_sec_write/read_req. state_code is held at 0 while sd_init_done is low.
- S_IDLE:
  - state_code = 1.
  - On capture: sd_sec_write_addr <= slot_addr, byte_cnt <= 0, read_req <= 1, go to S_REQ.
- S_REQ:
  - state_code = 2.
  - On read_req_ack: read_req <= 0; preload byte 0 ('B'); go to S_WRITE.
- S_WRITE:
  - state_code = 3; sd_sec_write = 1.
  - On each sd_sec_write_data_req: byte_cnt += 1, sec_byte += 1. Within 2 cycles, sd_sec_write_data holds the byte for the new byte_cnt.
  - Byte source by byte_cnt:
    - 0..53: header, all fields little-endian. 'B','M'; FILE_LEN; 0 (4 bytes); offset 54; DIB size 40; IMG_W (32-bit); IMG_H (32-bit); planes 1 (16-bit); bpp 24 (16-bit); compression 0; IMG_BYTES; 2835; 2835; 0; 0.
    - 54..FILE_LEN-1: pixel bytes in order B, G, R.
    - FILE_LEN and above: 0x00 padding.
  - Pixel fetch: bmp_data_rd_en pulses when byte 53 is consumed and when each R byte is consumed, except the last pixel. The latched pixel is used for the next three bytes. Exactly IMG_W*IMG_H pops per file.
  - On sd_sec_write_end: sd_sec_write <= 0, sec_byte <= 0. Then:
    - if sectors_done+1 < NSEC: sd_sec_write_addr += 1, stay in S_WRITE. sd_sec_write re-asserts the next cycle.
    - otherwise go to S_END.
- S_END:
  - file_sec_base <= slot_addr; slot_addr += SLOT; go to S_IDLE in 1 cycle.
- Controller constraint: sd_sec_write_data_req pulses are at least 3 cycles apart. A pulse arriving while not in S_WRITE is ignored.
- capture during a write is ignored (no queueing).
- A data_req and write_end in the same cycle: the byte is consumed first, then the end is handled.
- slot_addr wraps modulo 2^32.

Test Plan:
- IMG_W=4, IMG_H=2, BASE_SEC=8; capture, ack after 5 cycles, controller req every 4 cycles:
  - one sector at addr 8;
  - bytes 0..1 = 0x42,0x4D; bytes 2..5 = 0x4E,0,0,0 (FILE_LEN 78); byte 10 = 0x36; bytes 18..21 = 4,0,0,0; bytes 34..37 = 24,0,0,0;
  - bytes 54..77 = pixels in B,G,R order; bytes 78..511 = 0;
  - exactly 8 bmp_data_rd_en pulses.
- Same config, two captures back-to-back: second file at addr 16; file_sec_base = 16 after completion.
- IMG_W=8, IMG_H=32 (FILE_LEN 822, NSEC 2): sectors 8 then 9 written; byte 512 of the file = first byte of sector 9; pixel stream continuous across the sector boundary.
- sd_init_done dropped mid-sector: sd_sec_write falls the next cycle, state_code = 0, ready rises once sd_init_done returns; slot_addr unchanged.
- Async rst asserted mid-write: all outputs return to reset values immediately; no rd_en pulses after reset.
- capture pulsed during S_WRITE and S_REQ: ignored; exactly one file written.
